updown_cntr: RTL and testbench



---
 rtl/updown_cntr.sv | 39 +++
 tb/tb_updown_cntr.sv | 128 ++++++++++++
 2 files changed

// File: rtl/updown_cntr.sv
// rtl/updown_cntr.sv - free-running up/down counter, modulo wrap or saturating
// Define UPDOWN_CNTR_SATURATE_EN to make the count hold at 0 and 2^WIDTH-1.
module updown_cntr #(
  parameter int WIDTH       = 4,
  parameter int RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);
  localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_nxt;

  always_comb begin
    count_nxt = en ? (count + ONE) : (count - ONE);
`ifdef UPDOWN_CNTR_SATURATE_EN
    // At a range limit, a step further out is dropped instead of wrapping.
    if (en && (count == MAX_VAL)) begin
      count_nxt = count;
    end else if (!en && (count == '0)) begin
      count_nxt = count;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count <= RST_VAL;
    end else begin
      count <= count_nxt;
    end
  end

endmodule

// File: tb/tb_updown_cntr.sv
// tb/tb_updown_cntr.sv - directed plan plus randomized run against an arithmetic model
module tb_updown_cntr;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk;
  logic         rst;
  logic         en;
  logic [W-1:0] count;

  int model;
  int passed;
  int total;

  updown_cntr #(.WIDTH(W), .RESET_VALUE(0)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .count (count)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic check(input string tag, input int expected);
    logic [W-1:0] exp_v;
    exp_v = W'(expected);
    total++;
    assert (count === exp_v) passed++;
    else $error("FAIL %s: count=%0d expected=%0d", tag, count, exp_v);
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks, returns at the next falling edge.
  task automatic step(input logic r, input logic e, input string tag);
    rst = r;
    en  = e;
    @(posedge clk);
    if (!r) begin
      model = 0;
    end else if (e) begin
`ifdef UPDOWN_CNTR_SATURATE_EN
      model = (model == M - 1) ? model : model + 1;
`else
      model = (model + 1) % M;
`endif
    end else begin
`ifdef UPDOWN_CNTR_SATURATE_EN
      model = (model == 0) ? 0 : model - 1;
`else
      model = (model + M - 1) % M;
`endif
    end
    #1;
    check(tag, model);
    @(negedge clk);
  endtask

  initial begin
    passed = 0;
    total  = 0;
    model  = 0;
    rst    = 1'b0;
    en     = 1'b1;
    @(negedge clk);

    // Reset holds zero while low, even with en high
    step(1'b0, 1'b1, "reset_edge0");
    check("reset_const0", 0);
    step(1'b0, 1'b1, "reset_edge1");
    check("reset_const1", 0);

    for (int i = 0; i < 20; i++) step(1'b1, 1'b1, "up_seq");
`ifdef UPDOWN_CNTR_SATURATE_EN
    check("up_final_sat", 15);
`else
    check("up_final_wrap", 4);
`endif

    for (int i = 0; i < 28; i++) step(1'b1, 1'b0, "down_seq");
`ifdef UPDOWN_CNTR_SATURATE_EN
    check("down_final_sat", 0);
`else
    check("down_final_wrap", 8);
`endif

    step(1'b0, 1'b0, "toggle_reset");
    step(1'b1, 1'b1, "toggle0");
    check("toggle0_const", 1);
    step(1'b1, 1'b0, "toggle1");
    check("toggle1_const", 0);
    step(1'b1, 1'b1, "toggle2");
    step(1'b1, 1'b1, "toggle3");
    check("toggle3_const", 2);
    step(1'b1, 1'b0, "toggle4");
    check("toggle4_const", 1);

    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, "to_nine");
    check("at_nine", 9);
    step(1'b0, 1'b1, "mid_reset");
    check("mid_reset_const", 0);
    step(1'b1, 1'b0, "release_down");
`ifdef UPDOWN_CNTR_SATURATE_EN
    check("release_down_const", 0);
`else
    check("release_down_const", 15);
`endif

    // Reset asserted between edges must not disturb count before the next edge
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, "pre_async");
    rst = 1'b0;
    #5;
    check("no_async_reset", model);
    @(posedge clk);
    model = 0;
    #1;
    check("sync_reset_taken", 0);
    @(negedge clk);

    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 19) != 0), 1'($urandom_range(0, 1)), "random");
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
